// File: rtl/idiot_operand_stack_pkg.sv
// Shared encodings for the IDIOT operand stack: stack commands, error causes
// and the datapath word width.
package idiot_operand_stack_pkg;

  localparam int WORD = 16;

  typedef enum logic [2:0] {
    STKnop  = 3'b000,
    STKpush = 3'b001,
    STKpop  = 3'b010,
    STKbin  = 3'b011,
    STKun   = 3'b100,
    STKdup  = 3'b101,
    STKswap = 3'b110,
    STKill  = 3'b111
  } stk_op_e;

  typedef enum logic [1:0] {
    ERRnone  = 2'b00,
    ERRover  = 2'b01,
    ERRunder = 2'b10,
    ERRill   = 2'b11
  } err_code_e;

endpackage

// File: rtl/idiot_stack_store.sv
// Stack storage: DEPTH x WIDTH registers with two combinational read ports
// and two write ports so SWAP can exchange entries in a single edge.
module idiot_stack_store #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    rd_top_addr,
  input  logic [AW-1:0]    rd_nos_addr,
  output logic [WIDTH-1:0] rd_top_data,
  output logic [WIDTH-1:0] rd_nos_data,
  input  logic             we_a,
  input  logic [AW-1:0]    wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [AW-1:0]    wa_b,
  input  logic [WIDTH-1:0] wd_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never cleared; reads are masked by depth in the parent.
  always_ff @(posedge clk) begin
    if (we_a) mem[wa_a] <= wd_a;
    if (we_b) mem[wa_b] <= wd_b;
  end

  assign rd_top_data = mem[rd_top_addr];
  assign rd_nos_data = mem[rd_nos_addr];

endmodule

// File: rtl/idiot_operand_stack.sv
// Operand stack feeding ALU X/Y: command decode, depth tracking and sticky
// overflow/underflow/illegal-op detection around the storage array.
module idiot_operand_stack
  import idiot_operand_stack_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       stk_op,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int AW = $clog2(DEPTH);

  stk_op_e          op;
  logic [CW-1:0]    depth_q, depth_nxt;
  logic [AW-1:0]    slot_lo, top_idx, nos_idx;
  logic [WIDTH-1:0] top_raw, nos_raw;
  logic             we_a, we_b;
  logic [AW-1:0]    wa_a, wa_b;
  logic [WIDTH-1:0] wd_a, wd_b;
  logic             err_hit;
  err_code_e        err_cause;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             is_empty, is_full, lt_two;

  assign op       = stk_op_e'(stk_op);
  assign slot_lo  = depth_q[AW-1:0];
  // Indices wrap modulo DEPTH, so depth==DEPTH still addresses the top slot.
  assign top_idx  = slot_lo - AW'(1);
  assign nos_idx  = slot_lo - AW'(2);
  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == CW'(DEPTH));
  assign lt_two   = (depth_q < CW'(2));

  idiot_stack_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_store (
    .clk         (clk),
    .rd_top_addr (top_idx),
    .rd_nos_addr (nos_idx),
    .rd_top_data (top_raw),
    .rd_nos_data (nos_raw),
    .we_a        (we_a),
    .wa_a        (wa_a),
    .wd_a        (wd_a),
    .we_b        (we_b),
    .wa_b        (wa_b),
    .wd_b        (wd_b)
  );

  assign tos = is_empty ? '0 : top_raw;
  assign nos = lt_two   ? '0 : nos_raw;

  always_comb begin
    depth_nxt = depth_q;
    we_a      = 1'b0;
    wa_a      = slot_lo;
    wd_a      = din;
    we_b      = 1'b0;
    wa_b      = nos_idx;
    wd_b      = tos;
    err_hit   = 1'b0;
    err_cause = ERRnone;
    unique case (op)
      STKnop: ;
      STKpush: begin
        if (is_full) begin
          err_hit = 1'b1; err_cause = ERRover;
        end else begin
          we_a = 1'b1; depth_nxt = depth_q + CW'(1);
        end
      end
      STKpop: begin
        if (is_empty) begin
          err_hit = 1'b1; err_cause = ERRunder;
        end else begin
          depth_nxt = depth_q - CW'(1);
        end
      end
      STKbin: begin
        if (lt_two) begin
          err_hit = 1'b1; err_cause = ERRunder;
        end else begin
          we_a = 1'b1; wa_a = nos_idx; wd_a = wdata;
          depth_nxt = depth_q - CW'(1);
        end
      end
      STKun: begin
        if (is_empty) begin
          err_hit = 1'b1; err_cause = ERRunder;
        end else begin
          we_a = 1'b1; wa_a = top_idx; wd_a = wdata;
        end
      end
      STKdup: begin
        // Empty is checked first: duplicating nothing is an underflow.
        if (is_empty) begin
          err_hit = 1'b1; err_cause = ERRunder;
        end else if (is_full) begin
          err_hit = 1'b1; err_cause = ERRover;
        end else begin
          we_a = 1'b1; wd_a = tos; depth_nxt = depth_q + CW'(1);
        end
      end
      STKswap: begin
        if (lt_two) begin
          err_hit = 1'b1; err_cause = ERRunder;
        end else begin
          we_a = 1'b1; wa_a = top_idx; wd_a = nos;
          we_b = 1'b1; wa_b = nos_idx; wd_b = tos;
        end
      end
      default: begin
        err_hit = 1'b1; err_cause = ERRill;
      end
    endcase
    if (reset) begin
      we_a = 1'b0;
      we_b = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      depth_q <= depth_nxt;
      if (err_hit && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= err_cause;
      end
    end
  end

  assign depth    = depth_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
